// File: rtl/nibble_rx_if.sv
// ============================================================================
// Module : nibble_rx_if
// Brief  : Serial line and recovered-symbol bundle for the nibble receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface nibble_rx_if #(
    parameter int DATA_W = 4
);
    logic              rx;
    logic [DATA_W-1:0] sym;
    logic              sym_valid;
    logic              frame_err;
    logic              parity_err;

    // master drives the line and consumes symbols; slave is the receiver
    modport master (
        output rx,
        input  sym,
        input  sym_valid,
        input  frame_err,
        input  parity_err
    );

    modport slave (
        input  rx,
        output sym,
        output sym_valid,
        output frame_err,
        output parity_err
    );
endinterface

`default_nettype wire

// File: rtl/nibble_rx.sv
// ============================================================================
// Module : nibble_rx
// Brief  : Framed serial nibble receiver (start, LSB-first data, [parity], stop).
//          Optional even parity enabled by defining NIBBLE_RX_PARITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nibble_rx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire logic  clk,
    input  wire logic  rst,
    nibble_rx_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] C_CNT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef NIBBLE_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic              r_rx_s1;
    logic              r_rx_s;
    logic              r_rx_q;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_sym;
    logic              r_sym_valid;
    logic              r_frame_err;

    state_t            w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [IDX_W-1:0]  w_idx_nx;
    logic [DATA_W-1:0] w_shreg_nx;
    logic [DATA_W-1:0] w_sym_nx;
    logic              w_sym_valid_nx;
    logic              w_frame_err_nx;
    logic              w_parity_err_nx;
    logic              w_par_fault;

`ifdef NIBBLE_RX_PARITY_EN
    logic r_par_fault;
    logic r_parity_err;
    logic w_par_fault_nx;

    assign w_par_fault = r_par_fault;
`else
    assign w_par_fault = 1'b0;
`endif

    // Line synchroniser and edge register idle high so reset never fakes a start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_q  <= 1'b1;
        end else begin
            r_rx_s1 <= bus.rx;
            r_rx_s  <= r_rx_s1;
            r_rx_q  <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_shreg     <= w_shreg_nx;
            r_sym       <= w_sym_nx;
            r_sym_valid <= w_sym_valid_nx;
            r_frame_err <= w_frame_err_nx;
        end
    end

`ifdef NIBBLE_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_fault  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_fault  <= w_par_fault_nx;
            r_parity_err <= w_parity_err_nx;
        end
    end
`endif

    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt + 1'b1;
        w_idx_nx        = r_idx;
        w_shreg_nx      = r_shreg;
        w_sym_nx        = r_sym;
        w_sym_valid_nx  = 1'b0;
        w_frame_err_nx  = 1'b0;
        w_parity_err_nx = 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
        w_par_fault_nx  = r_par_fault;
`endif

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                // only a genuine 1->0 transition starts a frame
                if (r_rx_q && !r_rx_s) begin
                    w_state_nx = S_START;
                end
            end

            S_START: begin
                if (r_cnt == C_CNT_MID) begin
                    w_cnt_nx = '0;
                    if (!r_rx_s) begin
                        w_state_nx = S_DATA;
                        w_idx_nx   = '0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (r_cnt == C_CNT_END) begin
                    w_cnt_nx          = '0;
                    w_shreg_nx[r_idx] = r_rx_s;
                    if (r_idx == C_IDX_LAST) begin
`ifdef NIBBLE_RX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end

`ifdef NIBBLE_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == C_CNT_END) begin
                    w_cnt_nx       = '0;
                    w_par_fault_nx = (^r_shreg) ^ r_rx_s;
                    w_state_nx     = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (r_cnt == C_CNT_END) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
                    if (!r_rx_s) begin
                        w_frame_err_nx  = 1'b1;
                        w_parity_err_nx = w_par_fault;
                    end else if (w_par_fault) begin
                        w_parity_err_nx = 1'b1;
                    end else begin
                        w_sym_nx       = r_shreg;
                        w_sym_valid_nx = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign bus.sym       = r_sym;
    assign bus.sym_valid = r_sym_valid;
    assign bus.frame_err = r_frame_err;
`ifdef NIBBLE_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_rx.sv
// ============================================================================
// Module : tb_nibble_rx
// Brief  : Randomized scoreboard bench for nibble_rx (honours NIBBLE_RX_PARITY_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_rx;

    localparam int DATA_W = 4;
    localparam int CLKS   = 4;
`ifdef NIBBLE_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // cycles from E0 (first edge seeing the start bit) to the result pulse
    localparam int LAT = 2 + CLKS/2 + (DATA_W+1)*CLKS + (PAR ? CLKS : 0);

    typedef struct {
        int                cyc;
        logic [2:0]        kind;   // {sym_valid, frame_err, parity_err}
        logic [DATA_W-1:0] sym;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [DATA_W-1:0] model_sym;

    nibble_rx_if #(.DATA_W(DATA_W)) bus ();

    nibble_rx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: every pulse must match the oldest pending expectation
    always @(posedge clk) begin
        logic [2:0] w;
        exp_t       e;
        #1;
        w = {bus.sym_valid, bus.frame_err, bus.parity_err};
        if (w != 3'b000) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {29'd0, w}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("event_cycle", cyc, e.cyc);
                check_eq("event_kind", {29'd0, w}, {29'd0, e.kind});
                if (e.kind[2]) model_sym = e.sym;
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check_eq("missing_pulse", 32'd0, {29'd0, e.kind});
        end
        check_eq("sym", {28'd0, bus.sym}, {28'd0, model_sym});
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Expected outcome follows directly from the frame contents
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop, input logic par_flip);
        exp_t e;
        logic fault;
        logic p;
        fault = PAR && par_flip;
        p     = (^data) ^ par_flip;
        e.cyc = cyc + 1 + LAT;
        e.sym = data;
        if (!stop)      e.kind = {2'b01, fault};
        else if (fault) e.kind = 3'b001;
        else            e.kind = 3'b100;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(data[i]);
        if (PAR) send_bit(p);
        send_bit(stop);
    endtask

    initial begin
        logic [DATA_W-1:0] pat [6];
        logic [DATA_W-1:0] d;
        logic              stp;
        logic              pf;
        pat = '{4'h1, 4'h0, 4'h2, 4'h2, 4'h1, 4'h0};

        // reset with the line low
        model_sym = '0;
        bus.rx    = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {29'd0, bus.sym_valid, bus.frame_err, bus.parity_err}, 32'd0);
        check_eq("rst_sym", {28'd0, bus.sym}, 32'd0);
        rst    = 1'b0;
        bus.rx = 1'b1;
        repeat (50) @(negedge clk);

        send_frame(4'h1, 1'b1, 1'b0);
        idle(8);

        foreach (pat[i]) send_frame(pat[i], 1'b1, 1'b0);
        idle(8);

        // framing error, then line held low must not start a frame
        send_frame(4'hA, 1'b0, 1'b0);
        bus.rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(4);
        send_frame(4'h3, 1'b1, 1'b0);
        idle(8);

        // one-cycle glitch
        bus.rx = 1'b0;
        @(negedge clk);
        idle(20);

        // reset in the middle of the data bits of 0x5
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst       = 1'b1;
        model_sym = '0;
        bus.rx    = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(4);
        send_frame(4'h6, 1'b1, 1'b0);
        idle(8);

        if (PAR) begin
            send_frame(4'h7, 1'b1, 1'b0);
            send_frame(4'h7, 1'b1, 1'b1);
            idle(8);
        end

        // randomized frames, mixed gaps and faults
        for (int k = 0; k < 40; k++) begin
            d   = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
            stp = ($urandom_range(0, 5) != 0);
            pf  = ($urandom_range(0, 5) == 0);
            send_frame(d, stp, pf);
            if (stp) idle($urandom_range(0, 3));
            else     idle($urandom_range(1, 3));
        end

        idle(LAT + 8);
        check_eq("pending_events", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
